// File: rtl/cpu_hazard_pkg.sv
// cpu_hazard_pkg: shared constants and scoreboard entry type for the forwarding/hazard unit.
//   FWD_RF            forward select value meaning "read the register file"
//   ST_EX/ST_MEM/ST_WB stage indices after ID
//   entry_t           one in-flight writer {v, rd, lat}
package cpu_hazard_pkg;
   localparam int FWD_RF = 0;
   localparam int ST_EX = 1;
   localparam int ST_MEM = 2;
   localparam int ST_WB = 3;
   // Fixed-width fields so the type can be shared; AW and LAT_W must fit.
   localparam int ENT_RD_W = 8;
   localparam int ENT_LAT_W = 8;
   typedef struct packed {
      logic v;
      logic [ENT_RD_W-1:0] rd;
      logic [ENT_LAT_W-1:0] lat;
   } entry_t;
endpackage

// File: rtl/fwd_hazard_scoreboard_if.sv
// fwd_hazard_scoreboard_if: ID-stage bundle between the pipeline control and the hazard scoreboard.
//   master (ID stage): drives issue_*, src_*, hold, flush; reads fwd_sel, stall, stall_cnt
//   slave (scoreboard): the reverse
interface fwd_hazard_scoreboard_if #(
   parameter int AW = 5,
   parameter int NUM_SRC = 2,
   parameter int DEPTH = 3,
   parameter int LAT_W = $clog2(DEPTH),
   parameter int SEL_W = $clog2(DEPTH + 1),
   parameter int CNT_W = 16
);
   logic issue_valid;
   logic issue_wrEn;
   logic [AW-1:0] issue_rd;
   logic [LAT_W-1:0] issue_lat;
   logic [NUM_SRC*AW-1:0] src_addr;
   logic [NUM_SRC-1:0] src_used;
   logic hold;
   logic flush;
   logic [NUM_SRC*SEL_W-1:0] fwd_sel;
   logic stall;
   logic [CNT_W-1:0] stall_cnt;
   modport master (
      output issue_valid, issue_wrEn, issue_rd, issue_lat, src_addr, src_used, hold, flush,
      input fwd_sel, stall, stall_cnt
   );
   modport slave (
      input issue_valid, issue_wrEn, issue_rd, issue_lat, src_addr, src_used, hold, flush,
      output fwd_sel, stall, stall_cnt
   );
endinterface

// File: rtl/fwd_hazard_scoreboard_src_match.sv
// fwd_src_match: per-source priority lookup over the in-flight writers.
//   ent         scoreboard entries, index 1 = youngest (EX)
//   addr, used  source register address and whether it is read
//   sel         0 = register file, s = forward from stage s
//   need_stall  youngest matching producer has no result yet
module fwd_src_match
   import cpu_hazard_pkg::*;
#(
   parameter int AW = 5,
   parameter int DEPTH = 3,
   parameter int SEL_W = 2
) (
   input entry_t [DEPTH:1] ent,
   input logic [AW-1:0] addr,
   input logic used,
   output logic [SEL_W-1:0] sel,
   output logic need_stall
);
   // Scan oldest to youngest so the lowest matching stage overrides.
   always_comb begin
      sel = SEL_W'(FWD_RF);
      need_stall = 1'b0;
      for (int s = DEPTH; s >= ST_EX; s--)
         if (used && addr != '0 && ent[s].v && ent[s].rd == ENT_RD_W'(addr)) begin
            sel = (s > int'(ent[s].lat)) ? SEL_W'(s) : SEL_W'(FWD_RF);
            need_stall = s <= int'(ent[s].lat);
         end
   end
endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard: shift-register scoreboard of in-flight writers driving bypass selects and the ID stall.
//   clk, reset_n  pipeline clock, asynchronous active-low reset
//   bus (slave)   issue/source info in; fwd_sel, stall, saturating stall_cnt out
module fwd_hazard_scoreboard
   import cpu_hazard_pkg::*;
#(
   parameter int AW = 5,
   parameter int NUM_SRC = 2,
   parameter int DEPTH = 3,
   parameter int LAT_W = $clog2(DEPTH),
   parameter int SEL_W = $clog2(DEPTH + 1),
   parameter int CNT_W = 16
) (
   input logic clk,
   input logic reset_n,
   fwd_hazard_scoreboard_if.slave bus
);
   if (DEPTH < ST_MEM || AW > ENT_RD_W || LAT_W > ENT_LAT_W)
      $error("fwd_hazard_scoreboard: unsupported parameter set");
   entry_t [DEPTH:1] ent;
   entry_t [DEPTH:1] ent_nxt;
   logic [NUM_SRC-1:0] need;
   logic [CNT_W-1:0] cnt;
   logic alloc;
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_match #(.AW(AW), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match (
         .ent(ent),
         .addr(bus.src_addr[i*AW +: AW]),
         .used(bus.src_used[i]),
         .sel(bus.fwd_sel[i*SEL_W +: SEL_W]),
         .need_stall(need[i])
      );
   end
   assign bus.stall = bus.issue_valid & |need;
   assign bus.stall_cnt = cnt;
   assign alloc = bus.issue_valid & bus.issue_wrEn & (bus.issue_rd != '0) & ~bus.stall & ~bus.flush;
   // Flush kills both the instruction in ID (no alloc) and the one leaving EX.
   always_comb begin
      ent_nxt = ent;
      ent_nxt[DEPTH:2] = ent[DEPTH-1:1];
      ent_nxt[ST_MEM].v = ent[ST_EX].v & ~bus.flush;
      ent_nxt[ST_EX] = alloc ? entry_t'{v: 1'b1, rd: ENT_RD_W'(bus.issue_rd), lat: ENT_LAT_W'(bus.issue_lat)} : '0;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         ent <= '0;
         cnt <= '0;
      end else if (!bus.hold) begin
         ent <= ent_nxt;
         if (bus.stall && cnt != '1) cnt <= cnt + 1'b1;
      end
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb_fwd_hazard_scoreboard: directed vectors with a queue-based scoreboard; a second DUT with a 4-bit counter checks saturation.
module tb_fwd_hazard_scoreboard;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int checks = 0;
   int errors = 0;
   bit probe = 1'b0;
   typedef struct {
      string n;
      int fs;
      bit st;
      int c;
   } exp_t;
   exp_t q[$];
   always #5 clk = ~clk;
   fwd_hazard_scoreboard_if bus ();
   fwd_hazard_scoreboard_if #(.CNT_W(4)) sbus ();
   assign sbus.issue_valid = bus.issue_valid;
   assign sbus.issue_wrEn = bus.issue_wrEn;
   assign sbus.issue_rd = bus.issue_rd;
   assign sbus.issue_lat = bus.issue_lat;
   assign sbus.src_addr = bus.src_addr;
   assign sbus.src_used = bus.src_used;
   assign sbus.hold = bus.hold;
   assign sbus.flush = bus.flush;
   fwd_hazard_scoreboard dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   fwd_hazard_scoreboard #(.CNT_W(4)) dut_sat (.clk(clk), .reset_n(reset_n), .bus(sbus));
   task automatic go(input bit v, input bit we, input int rd, input int lat, input int a0, input bit u0,
                     input int a1 = 0, input bit u1 = 0, input bit h = 0, input bit f = 0);
      @(posedge clk);
      #1;
      bus.issue_valid = v;
      bus.issue_wrEn = we;
      bus.issue_rd = 5'(rd);
      bus.issue_lat = 2'(lat);
      bus.src_addr = {5'(a1), 5'(a0)};
      bus.src_used = {u1, u0};
      bus.hold = h;
      bus.flush = f;
   endtask
   task automatic idle(input int a0 = 0, input bit u0 = 0, input int a1 = 0, input bit u1 = 0);
      go(0, 0, 0, 0, a0, u0, a1, u1);
   endtask
   task automatic expect_out(input string n, input int fs, input bit st, input int c);
      exp_t e;
      e.n = n;
      e.fs = fs;
      e.st = st;
      e.c = c;
      q.push_back(e);
      probe = 1'b1;
   endtask
   task automatic chk(input string n, input string what, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s.%s actual=%0d expected=%0d", n, what, act, want);
      end
   endtask
   initial forever begin
      @(negedge clk);
      if (probe) begin
         probe = 1'b0;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL probe_without_expectation actual=0 expected=1");
         end else begin
            exp_t e;
            e = q.pop_front();
            chk(e.n, "fwd_sel", 32'(bus.fwd_sel), e.fs);
            chk(e.n, "stall", 32'(bus.stall), 32'(e.st));
            chk(e.n, "stall_cnt", 32'(bus.stall_cnt), e.c);
            chk(e.n, "sat_cnt", 32'(sbus.stall_cnt), (e.c > 15) ? 15 : e.c);
         end
      end
   end
   initial begin
      int c;
      bus.issue_valid = 0;
      bus.issue_wrEn = 0;
      bus.issue_rd = '0;
      bus.issue_lat = '0;
      bus.src_addr = '0;
      bus.src_used = '0;
      bus.hold = 0;
      bus.flush = 0;
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      idle();
      expect_out("reset", 0, 0, 0);
      // ALU chain on r3
      go(1, 1, 3, 0, 0, 0);
      expect_out("issue_r3", 0, 0, 0);
      go(1, 0, 0, 0, 3, 1);
      expect_out("alu_s1", 4'b0001, 0, 0);
      go(1, 0, 0, 0, 0, 0, 3, 1);
      expect_out("alu_s2", 4'b1000, 0, 0);
      go(1, 0, 0, 0, 3, 1, 3, 1);
      expect_out("alu_s3", 4'b1111, 0, 0);
      go(1, 0, 0, 0, 3, 1);
      expect_out("alu_gone", 0, 0, 0);
      // Load-use on r5; the stalled r6 write is retried next cycle
      go(1, 1, 5, 1, 0, 0);
      expect_out("issue_ld_r5", 0, 0, 0);
      go(1, 1, 6, 0, 5, 1);
      expect_out("load_use_stall", 0, 1, 0);
      go(1, 1, 6, 0, 5, 1);
      expect_out("load_use_fwd", 4'b0010, 0, 1);
      idle(6, 1, 5, 1);
      expect_out("r6_s1_r5_s3", 4'b1101, 0, 1);
      // Youngest wins and r0
      go(1, 1, 7, 0, 0, 0);
      expect_out("issue_r7a", 0, 0, 1);
      go(1, 1, 8, 0, 0, 0);
      expect_out("issue_r8", 0, 0, 1);
      go(1, 1, 7, 0, 0, 0);
      expect_out("issue_r7b", 0, 0, 1);
      go(1, 1, 0, 0, 7, 1, 0, 1);
      expect_out("youngest_and_r0", 4'b0001, 0, 1);
      idle(7, 1, 8, 1);
      expect_out("after_r0_writer", 4'b1110, 0, 1);
      // Flush kills the load leaving EX
      go(1, 1, 4, 1, 0, 0);
      expect_out("issue_ld_r4", 0, 0, 1);
      go(1, 1, 9, 0, 0, 0, 0, 0, 0, 1);
      expect_out("flush", 0, 0, 1);
      idle(4, 1);
      expect_out("flushed_r4", 0, 0, 1);
      // Flush and stall together: stall counted, flush still kills
      go(1, 1, 10, 1, 0, 0);
      expect_out("issue_ld_r10", 0, 0, 1);
      go(1, 1, 11, 0, 10, 1, 0, 0, 0, 1);
      expect_out("flush_with_stall", 0, 1, 1);
      idle(10, 1, 11, 1);
      expect_out("flushed_r10_r11", 0, 0, 2);
      // Hold freezes everything, stall stays visible
      go(1, 1, 12, 1, 0, 0);
      expect_out("issue_ld_r12", 0, 0, 2);
      for (int k = 0; k < 5; k++) begin
         go(1, 0, 0, 0, 12, 1, 0, 0, 1);
         expect_out("hold_stall", 0, 1, 2);
      end
      go(1, 0, 0, 0, 12, 1);
      expect_out("hold_released", 0, 1, 2);
      go(1, 0, 0, 0, 12, 1);
      expect_out("hold_then_fwd", 4'b0010, 0, 3);
      // Reset in the middle of a stall
      go(1, 1, 13, 2, 0, 0);
      expect_out("issue_ld_r13", 0, 0, 3);
      go(1, 0, 0, 0, 13, 1);
      expect_out("pre_reset_stall", 0, 1, 3);
      go(1, 0, 0, 0, 13, 1);
      #1 reset_n = 1'b0;
      expect_out("reset_async", 0, 0, 0);
      @(posedge clk);
      #3 reset_n = 1'b1;
      go(1, 0, 0, 0, 13, 1);
      expect_out("reset_empty", 0, 0, 0);
      // lat = DEPTH-1 only forwards from the last stage
      go(1, 1, 14, 2, 0, 0);
      expect_out("issue_lat2", 0, 0, 0);
      go(1, 0, 0, 0, 14, 1);
      expect_out("lat2_s1", 0, 1, 0);
      go(1, 0, 0, 0, 14, 1);
      expect_out("lat2_s2", 0, 1, 1);
      go(1, 0, 0, 0, 14, 1);
      expect_out("lat2_s3", 4'b0011, 0, 2);
      // Twenty more stall cycles: wide counter keeps going, 4-bit one pins at 15
      c = 2;
      for (int k = 0; k < 10; k++) begin
         go(1, 1, 15, 2, 0, 0);
         go(1, 0, 0, 0, 15, 1);
         expect_out("sat_stall_a", 0, 1, c);
         c++;
         go(1, 0, 0, 0, 15, 1);
         expect_out("sat_stall_b", 0, 1, c);
         c++;
         go(1, 0, 0, 0, 15, 1);
         expect_out("sat_fwd", 4'b0011, 0, c);
      end
      idle();
      expect_out("sat_final", 0, 0, 22);
      repeat (2) @(posedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL leftover_expectations actual=%0d expected=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
